decoder_seq: RTL
================

DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 The block SHALL expose parameter SEL_W, default 2, meaning select width; the block SHALL have N=2^SEL_W outputs, and SEL_W SHALL be in the range 1..6.
REQ-002 The block SHALL expose parameter STEP, default 1, meaning clock cycles per scan advance; STEP SHALL be in the range 1..255.
REQ-003 The block SHALL expose parameter ACT_LOW, default 0; when ACT_LOW=1, every dout bit SHALL be inverted (active line 0, inactive lines 1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The block SHALL have port en, input, 1 bit: global advance/accept enable.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 DIRECT, 01 SCAN_UP, 10 SCAN_DN, 11 OFF.
REQ-008 The block SHALL have port sel, input, SEL_W bits: the direct-mode select value.
REQ-009 The block SHALL have port sel_valid, input, 1 bit: sel is offered.
REQ-010 The block SHALL have port sel_ready, output, 1 bit: the block accepts sel this cycle.
REQ-011 The block SHALL have port dout, output, N bits: the registered one-hot decode.
REQ-012 The block SHALL have port idx, output, SEL_W bits: the currently selected index.
REQ-013 The block SHALL have port out_valid, output, 1 bit: dout carries a live selection.
REQ-014 The block SHALL have port wrap, output, 1 bit: one-cycle pulse on scan wrap-around.

Function
REQ-015 The block SHALL have a two-state FSM: IDLE (no live selection) and RUN (live selection); out_valid SHALL be 1 exactly when the FSM is in RUN.
REQ-016 dout SHALL be registered: dout = onehot(idx) in RUN, all lines inactive in IDLE, then XORed with {N{ACT_LOW}}.
REQ-017 sel_ready SHALL be combinational and equal en && (mode==DIRECT).
REQ-018 In DIRECT, on a cycle with sel_valid && sel_ready, the block SHALL set idx<=sel and FSM<=RUN; dout/idx SHALL reflect the new sel on the next cycle (latency 1).
REQ-019 In DIRECT with no handshake, idx, dout and the FSM state SHALL hold.
REQ-020 In SCAN_UP/SCAN_DN with en=1, an IDLE FSM SHALL go to RUN at the next edge without changing idx.
REQ-021 In SCAN_UP/SCAN_DN with en=1 and the FSM in RUN, an internal 8-bit step counter SHALL count 0..STEP-1; when it equals STEP-1, the block SHALL wrap it to 0 and advance idx by +1 (UP) or -1 (DN), modulo N.
REQ-022 wrap SHALL be 1 for exactly the cycle after an advance from N-1 to 0 (UP) or from 0 to N-1 (DN), and 0 otherwise.
REQ-023 In scan modes, sel_valid SHALL be ignored and sel_ready SHALL be 0.
REQ-024 In OFF, the FSM SHALL go to IDLE at the next edge, with dout inactive, idx held, the step counter cleared and sel_ready=0.
REQ-025 With en=0, the block SHALL freeze idx, the step counter, the FSM state and dout, and SHALL hold wrap at 0; mode==OFF SHALL still force IDLE regardless of en.
REQ-026 On any cycle where mode differs from the previous cycle, the step counter SHALL clear to 0 and idx SHALL be retained, so that a scan resumes from the current idx.
REQ-027 With STEP=1, idx SHALL advance every enabled RUN cycle.
REQ-028 A single DIRECT handshake SHALL be accepted per cycle, with no skid buffer; the offer is not stored when sel_ready=0.

Reset
REQ-029 While rst_n=0, the block SHALL force idx=0, step counter=0, FSM=IDLE, out_valid=0, wrap=0 and dout=all inactive ({N{ACT_LOW}}), independent of clk.
REQ-030 After rst_n is released, normal operation SHALL begin at the first rising edge of clk.
REQ-031 Reset asserted mid-scan or mid-handshake SHALL abort the operation with no residual wrap pulse.

Verification
REQ-032 Scenario: SEL_W=2, DIRECT, en=1, apply sel=0,1,2,3 with sel_valid=1 -> dout=0001,0010,0100,1000, each one cycle after its sel.
REQ-033 Scenario: SEL_W=2, SCAN_UP, STEP=1, from idx=3 -> idx=0 next advance, dout=0001, wrap=1 for exactly one cycle.
REQ-034 Scenario: SEL_W=3, SCAN_DN, STEP=3, starting at idx=0 -> idx=7 after 3 RUN cycles with a wrap pulse, then idx=6 after 3 more cycles.
REQ-035 Scenario: ACT_LOW=1, SEL_W=2, DIRECT sel=2 -> dout=1011; OFF -> dout=1111, out_valid=0, idx stays 2.
REQ-036 Scenario: SCAN_UP with en toggled 0 for 4 cycles -> idx and step counter frozen, resuming from the same count when en returns to 1.
REQ-037 Scenario: rst_n pulsed low mid-scan at idx=2 -> idx=0, dout=0000, out_valid=0 immediately, no wrap pulse.

Source files
------------

// File: rtl/decoder_seq.sv
// decoder_seq: registered one-hot decoder with a direct-select handshake and
// an up/down scan mode.
// A two-state FSM (IDLE/RUN) says whether dout carries a live selection.
// In scan modes the index advances once every STEP enabled RUN cycles.
// In that case wrap pulses for one cycle when the index rolls over.

module decoder_seq #(
    parameter int SEL_W   = 2,
    parameter int STEP    = 1,
    parameter int ACT_LOW = 0,
    localparam int N      = 1 << SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             sel_valid,
    output logic             sel_ready,
    output logic [N-1:0]     dout,
    output logic [SEL_W-1:0] idx,
    output logic             out_valid,
    output logic             wrap
);

    typedef enum logic [1:0] {
        MODE_DIRECT  = 2'b00,
        MODE_SCAN_UP = 2'b01,
        MODE_SCAN_DN = 2'b10,
        MODE_OFF     = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [7:0]       STEP_LAST = 8'(STEP - 1);
    localparam logic [N-1:0]     INACTIVE  = (ACT_LOW != 0) ? {N{1'b1}} : {N{1'b0}};
    localparam logic [SEL_W-1:0] IDX_MAX   = {SEL_W{1'b1}};
    localparam logic [SEL_W-1:0] IDX_ONE   = SEL_W'(1);

    // Parameter range guards, evaluated at elaboration time only.
    if (SEL_W < 1 || SEL_W > 6) begin : g_bad_sel_w
        $error("decoder_seq: SEL_W must be in 1..6");
    end
    if (STEP < 1 || STEP > 255) begin : g_bad_step
        $error("decoder_seq: STEP must be in 1..255");
    end

    state_e           r_state;
    mode_e            r_prev_mode;
    logic [SEL_W-1:0] r_idx;
    logic [7:0]       r_cnt;
    logic             r_wrap;
    logic [N-1:0]     r_dout;

    mode_e            w_mode;
    logic             w_mode_chg;
    logic             w_accept;
    state_e           w_state_nxt;
    logic [SEL_W-1:0] w_idx_nxt;
    logic [7:0]       w_cnt_nxt;
    logic             w_wrap_nxt;
    logic [N-1:0]     w_dout_nxt;

    assign w_mode     = mode_e'(mode);
    assign w_mode_chg = (w_mode != r_prev_mode);
    assign sel_ready  = en && (w_mode == MODE_DIRECT);
    assign w_accept   = sel_ready && sel_valid;

    // Next-state logic: FSM transition, index, step counter, wrap and decode.
    // NOTE: every signal assigned in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_wrap_nxt  = 1'b0;

        unique case (w_mode)
            MODE_OFF: begin
                // OFF overrides en: drop the selection, keep the index.
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 8'd0;
            end

            MODE_DIRECT: begin
                if (w_mode_chg) begin
                    w_cnt_nxt = 8'd0;
                end
                if (w_accept) begin
                    w_idx_nxt   = sel;
                    w_state_nxt = ST_RUN;
                end
            end

            MODE_SCAN_UP, MODE_SCAN_DN: begin
                // A fresh mode restarts the step count from the current index.
                if (w_mode_chg) begin
                    w_cnt_nxt = 8'd0;
                end
                if (en) begin
                    if (r_state == ST_IDLE) begin
                        w_state_nxt = ST_RUN;
                    end else if (!w_mode_chg) begin
                        if (r_cnt == STEP_LAST) begin
                            w_cnt_nxt = 8'd0;
                            if (w_mode == MODE_SCAN_UP) begin
                                w_idx_nxt  = r_idx + IDX_ONE;
                                w_wrap_nxt = (r_idx == IDX_MAX);
                            end else begin
                                w_idx_nxt  = r_idx - IDX_ONE;
                                w_wrap_nxt = (r_idx == '0);
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + 8'd1;
                        end
                    end
                end
            end
        endcase

        // Decode the next index so dout lines up with idx/out_valid.
        w_dout_nxt = INACTIVE;
        if (w_state_nxt == ST_RUN) begin
            w_dout_nxt = (N'(1) << w_idx_nxt) ^ INACTIVE;
        end
    end

    // State register with asynchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_prev_mode <= MODE_DIRECT;
            r_idx       <= '0;
            r_cnt       <= 8'd0;
            r_wrap      <= 1'b0;
            r_dout      <= INACTIVE;
        end else begin
            r_state     <= w_state_nxt;
            r_prev_mode <= w_mode;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_wrap      <= w_wrap_nxt;
            r_dout      <= w_dout_nxt;
        end
    end

    assign dout      = r_dout;
    assign idx       = r_idx;
    assign out_valid = (r_state == ST_RUN);
    assign wrap      = r_wrap;

endmodule
